// File: rtl/dm9000a_rx_reader_if.sv
// Host-bus and payload-stream signals between the DM9000A receive reader
// (master) and the Ethernet chip plus downstream consumer (slave).
interface dm9000a_rx_reader_if;
   logic        oEnetCs_n;
   logic        oEnetCmd;
   logic        oEnetIor_n;
   logic        oEnetIow_n;
   logic [15:0] oEnetDataOut;
   logic        oEnetDataOe;
   logic [15:0] iEnetDataIn;
   logic [15:0] oRxData;
   logic        oRxValid;
   logic        oRxLast;
   logic        iRxReady;

   modport master (
      output oEnetCs_n, oEnetCmd, oEnetIor_n, oEnetIow_n, oEnetDataOut, oEnetDataOe,
      input  iEnetDataIn,
      output oRxData, oRxValid, oRxLast,
      input  iRxReady
   );

   modport slave (
      input  oEnetCs_n, oEnetCmd, oEnetIor_n, oEnetIow_n, oEnetDataOut, oEnetDataOe,
      output iEnetDataIn,
      input  oRxData, oRxValid, oRxLast,
      output iRxReady
   );
endinterface

// File: rtl/dm9000a_rx_reader.sv
// DM9000A receive reader: runs the F0/F2 index + data-port read sequence for one
// frame and streams the payload words out over a valid/ready handshake.
module dm9000a_rx_reader #(
   parameter int SETUP_CLKS  = 1,
   parameter int STROBE_CLKS = 2,
   parameter int HOLD_CLKS   = 1,
   parameter int MAX_LEN     = 1536
) (
   input  logic                       iDm9000aClk,
   input  logic                       iRst_n,
   input  logic                       iRxStart,
   output logic                       oBusy,
   output logic                       oDone,
   output logic                       oNoPkt,
   output logic                       oBadHeader,
   output logic                       oRxErr,
   output logic [10:0]                oRxLen,
   dm9000a_rx_reader_if.master        busIf
);

   localparam int TOTAL_CLKS = SETUP_CLKS + STROBE_CLKS + HOLD_CLKS;
   localparam int CW         = $clog2(TOTAL_CLKS + 1);
   localparam logic [CW-1:0] CYC_LAST  = CW'(TOTAL_CLKS - 1);
   localparam logic [CW-1:0] STB_FIRST = CW'(SETUP_CLKS);
   localparam logic [CW-1:0] STB_END   = CW'(SETUP_CLKS + STROBE_CLKS);
   localparam logic [CW-1:0] SAMPLE    = CW'(SETUP_CLKS + STROBE_CLKS - 1);
   localparam logic [15:0]   MAX_LEN_W = 16'(MAX_LEN);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WR_IDX_F0 = 3'd1,
      RD_READY  = 3'd2,
      WR_IDX_F2 = 3'd3,
      RD_STATUS = 3'd4,
      RD_LEN    = 3'd5,
      RD_DATA   = 3'd6,
      DONE      = 3'd7
   } state_t;

   function automatic logic isRead(input state_t s);
      return (s == RD_READY) || (s == RD_STATUS) || (s == RD_LEN) || (s == RD_DATA);
   endfunction

   function automatic logic isWrite(input state_t s);
      return (s == WR_IDX_F0) || (s == WR_IDX_F2);
   endfunction

   state_t        state_r, state_s;
   logic [CW-1:0] cyc_r, cyc_s;
   logic          active_r, active_s;
   logic          cycEnd_s;
   logic [9:0]    wordCnt_r, wordCnt_s;
   logic [15:0]   rdData_r, rdData_s;
   logic [15:0]   readWord_s;
   logic [9:0]    wordsN_s;
   logic          discard_r, discard_s;
   logic          noPkt_r, noPkt_s;
   logic          badHdr_r, badHdr_s;
   logic          rxErr_r, rxErr_s;
   logic [10:0]   rxLen_r, rxLen_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic [15:0]   rxData_r, rxData_s;
   logic          rxValid_r, rxValid_s;
   logic          rxLast_r, rxLast_s;
   logic          csN_r, csN_s;
   logic          cmd_r, cmd_s;
   logic          iorN_r, iorN_s;
   logic          iowN_r, iowN_s;
   logic [15:0]   dataOut_r, dataOut_s;
   logic          dataOe_r, dataOe_s;
   logic          strobe_s;

   // With no hold time the sample clock is also the cycle's last clock.
   assign readWord_s = (HOLD_CLKS == 0) ? busIf.iEnetDataIn : rdData_r;
   assign wordsN_s   = readWord_s[10:1] + {9'd0, readWord_s[0]};

   // Next-state, bus-cycle sequencing and next values of every registered output.
   always_comb begin
      state_s   = state_r;
      active_s  = active_r;
      wordCnt_s = wordCnt_r;
      discard_s = discard_r;
      noPkt_s   = noPkt_r;
      badHdr_s  = badHdr_r;
      rxErr_s   = rxErr_r;
      rxLen_s   = rxLen_r;
      rxData_s  = rxData_r;
      rxValid_s = rxValid_r;
      rxLast_s  = rxLast_r;
      cycEnd_s  = active_r && (cyc_r == CYC_LAST);

      if (active_r && !cycEnd_s) begin
         cyc_s = cyc_r + CW'(1);
      end else begin
         cyc_s = CW'(0);
      end

      if (active_r && isRead(state_r) && (cyc_r == SAMPLE)) begin
         rdData_s = busIf.iEnetDataIn;
      end else begin
         rdData_s = rdData_r;
      end

      case (state_r)
         IDLE: begin
            if (iRxStart) begin
               state_s   = WR_IDX_F0;
               active_s  = 1'b1;
               noPkt_s   = 1'b0;
               badHdr_s  = 1'b0;
               rxErr_s   = 1'b0;
               discard_s = 1'b0;
               rxLen_s   = 11'd0;
            end else begin
               active_s  = 1'b0;
            end
         end
         WR_IDX_F0: begin
            if (cycEnd_s) begin
               state_s = RD_READY;
            end else begin
               state_s = WR_IDX_F0;
            end
         end
         RD_READY: begin
            if (cycEnd_s) begin
               case (readWord_s[7:0])
                  8'h01: begin
                     state_s = WR_IDX_F2;
                  end
                  8'h00: begin
                     noPkt_s  = 1'b1;
                     state_s  = DONE;
                     active_s = 1'b0;
                  end
                  default: begin
                     badHdr_s = 1'b1;
                     state_s  = DONE;
                     active_s = 1'b0;
                  end
               endcase
            end else begin
               state_s = RD_READY;
            end
         end
         WR_IDX_F2: begin
            if (cycEnd_s) begin
               state_s = RD_STATUS;
            end else begin
               state_s = WR_IDX_F2;
            end
         end
         RD_STATUS: begin
            if (cycEnd_s) begin
               state_s = RD_LEN;
               if (readWord_s[13:8] != 6'd0) begin
                  discard_s = 1'b1;
                  rxErr_s   = 1'b1;
               end else begin
                  discard_s = 1'b0;
               end
            end else begin
               state_s = RD_STATUS;
            end
         end
         RD_LEN: begin
            if (cycEnd_s) begin
               rxLen_s = readWord_s[10:0];
               if ((readWord_s == 16'd0) || (readWord_s > MAX_LEN_W)) begin
                  badHdr_s = 1'b1;
                  state_s  = DONE;
                  active_s = 1'b0;
               end else begin
                  wordCnt_s = wordsN_s;
                  state_s   = RD_DATA;
               end
            end else begin
               state_s = RD_LEN;
            end
         end
         RD_DATA: begin
            if (active_r) begin
               if (cycEnd_s) begin
                  wordCnt_s = wordCnt_r - 10'd1;
                  if (discard_r) begin
                     // Discarded frames still drain the chip so its read pointer advances.
                     if (wordCnt_r == 10'd1) begin
                        state_s  = DONE;
                        active_s = 1'b0;
                     end else begin
                        active_s = 1'b1;
                     end
                  end else begin
                     rxData_s  = readWord_s;
                     rxValid_s = 1'b1;
                     rxLast_s  = (wordCnt_r == 10'd1);
                     active_s  = 1'b0;
                  end
               end else begin
                  wordCnt_s = wordCnt_r;
               end
            end else if (rxValid_r && busIf.iRxReady) begin
               rxValid_s = 1'b0;
               rxLast_s  = 1'b0;
               if (wordCnt_r == 10'd0) begin
                  state_s = DONE;
               end else begin
                  active_s = 1'b1;
               end
            end else begin
               rxValid_s = rxValid_r;
            end
         end
         DONE: begin
            state_s  = IDLE;
            active_s = 1'b0;
         end
         default: begin
            state_s  = IDLE;
            active_s = 1'b0;
         end
      endcase

      busy_s   = (state_s != IDLE) && (state_s != DONE);
      done_s   = (state_s == DONE);
      csN_s    = !active_s;
      strobe_s = active_s && (cyc_s >= STB_FIRST) && (cyc_s < STB_END);
      iorN_s   = !(strobe_s && isRead(state_s));
      iowN_s   = !(strobe_s && isWrite(state_s));
      cmd_s    = active_s && isRead(state_s);
      dataOe_s = active_s && isWrite(state_s);
      if (active_s && (state_s == WR_IDX_F0)) begin
         dataOut_s = 16'h00F0;
      end else if (active_s && (state_s == WR_IDX_F2)) begin
         dataOut_s = 16'h00F2;
      end else begin
         dataOut_s = 16'h0000;
      end
   end

   // State and output registers.
   always_ff @(posedge iDm9000aClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_r   <= IDLE;
         cyc_r     <= CW'(0);
         active_r  <= 1'b0;
         wordCnt_r <= 10'd0;
         rdData_r  <= 16'd0;
         discard_r <= 1'b0;
         noPkt_r   <= 1'b0;
         badHdr_r  <= 1'b0;
         rxErr_r   <= 1'b0;
         rxLen_r   <= 11'd0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         rxData_r  <= 16'd0;
         rxValid_r <= 1'b0;
         rxLast_r  <= 1'b0;
         csN_r     <= 1'b1;
         cmd_r     <= 1'b0;
         iorN_r    <= 1'b1;
         iowN_r    <= 1'b1;
         dataOut_r <= 16'd0;
         dataOe_r  <= 1'b0;
      end else begin
         state_r   <= state_s;
         cyc_r     <= cyc_s;
         active_r  <= active_s;
         wordCnt_r <= wordCnt_s;
         rdData_r  <= rdData_s;
         discard_r <= discard_s;
         noPkt_r   <= noPkt_s;
         badHdr_r  <= badHdr_s;
         rxErr_r   <= rxErr_s;
         rxLen_r   <= rxLen_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         rxData_r  <= rxData_s;
         rxValid_r <= rxValid_s;
         rxLast_r  <= rxLast_s;
         csN_r     <= csN_s;
         cmd_r     <= cmd_s;
         iorN_r    <= iorN_s;
         iowN_r    <= iowN_s;
         dataOut_r <= dataOut_s;
         dataOe_r  <= dataOe_s;
      end
   end

   assign oBusy              = busy_r;
   assign oDone              = done_r;
   assign oNoPkt             = noPkt_r;
   assign oBadHeader         = badHdr_r;
   assign oRxErr             = rxErr_r;
   assign oRxLen             = rxLen_r;
   assign busIf.oEnetCs_n    = csN_r;
   assign busIf.oEnetCmd     = cmd_r;
   assign busIf.oEnetIor_n   = iorN_r;
   assign busIf.oEnetIow_n   = iowN_r;
   assign busIf.oEnetDataOut = dataOut_r;
   assign busIf.oEnetDataOe  = dataOe_r;
   assign busIf.oRxData      = rxData_r;
   assign busIf.oRxValid     = rxValid_r;
   assign busIf.oRxLast      = rxLast_r;

endmodule

// File: tb/tb_dm9000a_rx_reader.sv
// Bench for dm9000a_rx_reader: RX SRAM model behind the host bus, scoreboarded
// payload stream and index writes, and per-packet flag/count checks.
module tb_dm9000a_rx_reader;

   typedef struct packed {
      logic [15:0] d;
      logic [15:0] m;
      logic        l;
   } exp_t;

   logic        iDm9000aClk;
   logic        iRst_n;
   logic        iRxStart;
   logic        oBusy, oDone, oNoPkt, oBadHeader, oRxErr;
   logic [10:0] oRxLen;

   dm9000a_rx_reader_if busIf();

   dm9000a_rx_reader dut (
      .iDm9000aClk (iDm9000aClk),
      .iRst_n      (iRst_n),
      .iRxStart    (iRxStart),
      .oBusy       (oBusy),
      .oDone       (oDone),
      .oNoPkt      (oNoPkt),
      .oBadHeader  (oBadHeader),
      .oRxErr      (oRxErr),
      .oRxLen      (oRxLen),
      .busIf       (busIf.master)
   );

   logic [15:0] mem [0:1023];
   int          rdPtr;
   exp_t        expQ[$];
   logic [15:0] idxQ[$];
   exp_t        e;
   int checks, errors;
   int nReads, nWrites, hsCnt, validSeen, busyCnt, doneCnt, rdWhileValid;
   int rdyMode, rdyPhase;
   logic iorPrev, iowPrev;
   int expReads, expWrites, expHs;
   logic expNoPkt, expBad, expErr;
   logic [10:0] expLen;

   assign busIf.iEnetDataIn = mem[rdPtr[9:0]];

   initial begin
      iDm9000aClk = 1'b0;
      forever #20 iDm9000aClk = ~iDm9000aClk;
   end

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Downstream ready: tied high, or 1 clock on / 3 clocks off.
   initial begin
      busIf.iRxReady = 1'b1;
      rdyPhase = 0;
      forever begin
         @(posedge iDm9000aClk);
         #1;
         rdyPhase = (rdyPhase + 1) % 4;
         busIf.iRxReady = (rdyMode == 0) ? 1'b1 : (rdyPhase == 0);
      end
   end

   // Bus/stream monitor sampled mid-clock: chip read pointer, cycle counts, scoreboard.
   always @(negedge iDm9000aClk) begin
      if (iRst_n) begin
         if (!busIf.oEnetIor_n && iorPrev) begin
            nReads++;
            if (busIf.oRxValid) rdWhileValid++;
         end
         if (busIf.oEnetIor_n && !iorPrev) rdPtr++;
         if (!busIf.oEnetIow_n && iowPrev) begin
            nWrites++;
            if (idxQ.size() == 0) checkVal("idxExtra", 32'd1, 32'd0);
            else checkVal("idxData", {16'd0, busIf.oEnetDataOut}, {16'd0, idxQ.pop_front()});
            checkVal("idxOe", {31'd0, busIf.oEnetDataOe}, 32'd1);
         end
         if (busIf.oRxValid) validSeen++;
         if (oBusy) busyCnt++;
         if (oDone) doneCnt++;
         if (busIf.oRxValid && busIf.iRxReady) begin
            hsCnt++;
            if (expQ.size() == 0) checkVal("wordExtra", 32'd1, 32'd0);
            else begin
               e = expQ.pop_front();
               checkVal("word", {16'd0, busIf.oRxData & e.m}, {16'd0, e.d & e.m});
               checkVal("last", {31'd0, busIf.oRxLast}, {31'd0, e.l});
            end
         end
      end
      iorPrev = busIf.oEnetIor_n;
      iowPrev = busIf.oEnetIow_n;
   end

   task automatic startPkt(input logic [15:0] rdy, input logic [15:0] st, input logic [15:0] len, input int mode);
      logic good, lenOk;
      int n;
      good  = (rdy[7:0] == 8'h01);
      lenOk = (len != 16'd0) && (len <= 16'd1536);
      n     = (int'(len) + 1) / 2;
      mem[0] = rdy;
      mem[1] = st;
      mem[2] = len;
      for (int i = 0; i < 1000; i++) mem[3 + i] = 16'($urandom);
      rdPtr = 0;
      nReads = 0; nWrites = 0; hsCnt = 0; validSeen = 0; busyCnt = 0; doneCnt = 0; rdWhileValid = 0;
      expQ.delete();
      idxQ.delete();
      expNoPkt  = (rdy[7:0] == 8'h00);
      expBad    = !(expNoPkt || good) || (good && !lenOk);
      expErr    = good && (st[13:8] != 6'd0);
      expLen    = good ? len[10:0] : 11'd0;
      expWrites = good ? 2 : 1;
      expReads  = !good ? 1 : (!lenOk ? 3 : 3 + n);
      expHs     = (good && lenOk && !expErr) ? n : 0;
      idxQ.push_back(16'h00F0);
      if (good) idxQ.push_back(16'h00F2);
      for (int i = 0; i < expHs; i++) begin
         e.d = mem[3 + i];
         e.m = ((i == n - 1) && len[0]) ? 16'h00FF : 16'hFFFF;
         e.l = (i == n - 1);
         expQ.push_back(e);
      end
      rdyMode = mode;
      @(negedge iDm9000aClk);
      iRxStart = 1'b1;
      @(negedge iDm9000aClk);
      iRxStart = 1'b0;
   endtask

   task automatic finishPkt(input logic extraStart);
      logic seen;
      seen = 1'b0;
      if (extraStart) begin
         repeat (20) @(negedge iDm9000aClk);
         iRxStart = 1'b1;
         @(negedge iDm9000aClk);
         iRxStart = 1'b0;
      end
      for (int i = 0; i < 6000; i++) begin
         @(negedge iDm9000aClk);
         if (oDone) begin
            seen = 1'b1;
            break;
         end
      end
      checkVal("doneSeen", {31'd0, seen}, 32'd1);
      checkVal("busyAtDone", {31'd0, oBusy}, 32'd0);
      @(negedge iDm9000aClk);
      checkVal("donePulse", {31'd0, oDone}, 32'd0);
      checkVal("doneCnt", doneCnt, 32'd1);
      checkVal("noPkt", {31'd0, oNoPkt}, {31'd0, expNoPkt});
      checkVal("badHdr", {31'd0, oBadHeader}, {31'd0, expBad});
      checkVal("rxErr", {31'd0, oRxErr}, {31'd0, expErr});
      checkVal("rxLen", {21'd0, oRxLen}, {21'd0, expLen});
      checkVal("reads", nReads, expReads);
      checkVal("writes", nWrites, expWrites);
      checkVal("handshakes", hsCnt, expHs);
      checkVal("expLeft", expQ.size(), 32'd0);
      checkVal("idxLeft", idxQ.size(), 32'd0);
      checkVal("rdWhileValid", rdWhileValid, 32'd0);
      if (expHs == 0) begin
         checkVal("validSeen", validSeen, 32'd0);
         checkVal("busyClks", busyCnt, 4 * (expReads + expWrites));
      end
   endtask

   initial begin
      int waitCnt;
      checks = 0; errors = 0; rdyMode = 0; rdPtr = 0;
      iorPrev = 1'b1; iowPrev = 1'b1;
      iRst_n = 1'b0;
      iRxStart = 1'b0;
      repeat (3) @(negedge iDm9000aClk);
      checkVal("rstCs", {31'd0, busIf.oEnetCs_n}, 32'd1);
      checkVal("rstIor", {31'd0, busIf.oEnetIor_n}, 32'd1);
      checkVal("rstIow", {31'd0, busIf.oEnetIow_n}, 32'd1);
      checkVal("rstBusy", {31'd0, oBusy}, 32'd0);
      iRst_n = 1'b1;
      @(negedge iDm9000aClk);

      startPkt(16'h0000, 16'h0000, 16'd0, 0);    finishPkt(1'b0);
      startPkt(16'h0001, 16'h0000, 16'd64, 0);   finishPkt(1'b0);
      startPkt(16'h0001, 16'h0000, 16'd61, 1);   finishPkt(1'b0);
      startPkt(16'h0001, 16'h0200, 16'd100, 0);  finishPkt(1'b1);
      startPkt(16'h0055, 16'h0000, 16'd64, 0);   finishPkt(1'b0);
      startPkt(16'h0001, 16'h0000, 16'd0, 0);    finishPkt(1'b0);
      startPkt(16'h0001, 16'h0000, 16'd1600, 0); finishPkt(1'b0);
      startPkt(16'h0001, 16'h0000, 16'd1536, 0); finishPkt(1'b0);

      // Asynchronous reset in the middle of the payload stream.
      startPkt(16'h0001, 16'h0000, 16'd64, 1);
      waitCnt = 0;
      while (hsCnt < 3 && waitCnt < 2000) begin
         @(negedge iDm9000aClk);
         waitCnt++;
      end
      checkVal("midReached", {31'd0, (hsCnt >= 3)}, 32'd1);
      #7;
      iRst_n = 1'b0;
      #1;
      checkVal("arCs", {31'd0, busIf.oEnetCs_n}, 32'd1);
      checkVal("arIor", {31'd0, busIf.oEnetIor_n}, 32'd1);
      checkVal("arIow", {31'd0, busIf.oEnetIow_n}, 32'd1);
      checkVal("arCmd", {31'd0, busIf.oEnetCmd}, 32'd0);
      checkVal("arOe", {31'd0, busIf.oEnetDataOe}, 32'd0);
      checkVal("arValid", {31'd0, busIf.oRxValid}, 32'd0);
      checkVal("arLast", {31'd0, busIf.oRxLast}, 32'd0);
      checkVal("arBusy", {31'd0, oBusy}, 32'd0);
      checkVal("arLen", {21'd0, oRxLen}, 32'd0);
      checkVal("arDone", doneCnt, 32'd0);
      repeat (2) @(negedge iDm9000aClk);
      iRst_n = 1'b1;
      @(negedge iDm9000aClk);
      startPkt(16'h0001, 16'h0000, 16'd6, 0);    finishPkt(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm9000a_rx_reader.md
Name: dm9000a_rx_reader

Overview:
- Receive-side packet reader for the DM9000A Ethernet controller; it pulls received frames out of the chip's RX SRAM over the 16-bit host bus.
- It is the read counterpart of the DAQ transmit path.
- It is triggered by the interrupt/poll logic and runs the MRCMDX/MRCMD register sequence with parameterised bus timing.
- It streams payload words to downstream logic with a valid/ready handshake.

Parameters:
- SETUP_CLKS, 1, clocks from CS_n/CMD/address valid to strobe assertion
- STROBE_CLKS, 2, clocks IOR_n/IOW_n held low; read data sampled on the last strobe clock
- HOLD_CLKS, 1, clocks after strobe release before the next cycle
- MAX_LEN, 1536, largest legal frame length in bytes

Ports:
- iDm9000aClk  in  1  25 MHz clock
- iRst_n  in  1  asynchronous active-low reset
- iRxStart  in  1  single-clock pulse: read one packet
- oBusy  out  1  high from accepting iRxStart to oDone
- oDone  out  1  single-clock pulse when the sequence finishes
- oNoPkt  out  1  valid with oDone: ready byte was 0x00
- oBadHeader  out  1  valid with oDone: ready byte not 0x00/0x01, or illegal length
- oRxErr  out  1  valid with oDone: RX status byte had an error bit set (bits 0-5)
- oRxLen  out  11  byte length from the packet header, valid from header read until the next start
- oEnetCs_n  out  1  chip select
- oEnetCmd  out  1  0 = index port, 1 = data port
- oEnetIor_n  out  1  read strobe
- oEnetIow_n  out  1  write strobe
- oEnetDataOut  out  16  write data (index value)
- oEnetDataOe  out  1  drive enable for the data bus
- iEnetDataIn  in  16  bus read data
- oRxData  out  16  payload word, byte 0 in [7:0]
- oRxValid  out  1  payload word valid
- oRxLast  out  1  final payload word of the frame
- iRxReady  in  1  downstream accepts the word while oRxValid is high

Behaviour:
- Reset values: strobes and CS_n high; oEnetCmd 0; oEnetDataOe 0; oEnetDataOut 0; all flags, oRxValid, oRxLast 0; oRxLen 0; state IDLE. Reset mid-operation aborts immediately with no oDone.
- Bus cycle engine:
  - one cycle = SETUP_CLKS + STROBE_CLKS + HOLD_CLKS clocks; CS_n is low for the whole cycle.
  - Write cycle: oEnetDataOe is high for the whole cycle.
  - Read cycle: data is registered on the final strobe clock.
  - A default cycle is 4 clocks.
- FSM states, in order:
  - IDLE: accepts iRxStart only here; iRxStart while busy is ignored.
  - WR_IDX_F0: index write 0xF0.
  - RD_READY: data read; low byte 0x01 goes to WR_IDX_F2; 0x00 sets oNoPkt and goes to DONE; any other value sets oBadHeader and goes to DONE.
  - WR_IDX_F2: index write 0xF2.
  - RD_STATUS: data read; high byte is the RX status; status[5:0] != 0 sets the internal discard flag and oRxErr.
  - RD_LEN: data read; value is latched into oRxLen. 0 or > MAX_LEN sets oBadHeader and goes to DONE.
  - RD_DATA: reads N = (len+1)>>1 words.
  - DONE: oDone pulses one clock, then return to IDLE.
- RD_DATA details:
  - Each word read is presented with oRxValid, and the next read does not start until the handshake completes. oRxValid falls the clock after oRxValid & iRxReady.
  - oRxLast is high with the Nth word.
  - Discard mode reads all N words back-to-back with oRxValid held low; the chip read pointer must still advance.
  - Odd length: the last word is still read in full; its upper byte is don't-care.
- Word counter is 10 bits, counting down from N; the transition out of RD_DATA happens at count 0 after the last handshake.
- Flags are cleared on accepting iRxStart and remain stable after oDone until the next start.
- oBusy falls in the same clock as the oDone pulse.

Test Plan:
- Ready byte 0x00 -> 2 bus cycles (index write 0xF0, data read); oDone with oNoPkt=1; oRxValid never high; oBusy high for 8 clocks.
- Ready byte 0x01, status 0x0000, length 64, iRxReady tied 1 -> 32 words streamed in order; oRxLast with the 32nd word; oRxLen=64; oDone with all flags 0.
- Length 61, with iRxReady toggled 1 clock on / 3 clocks off -> 31 words; no bus read while oRxValid is high and unaccepted; oRxLast only on word 31.
- Status byte 0x02 (CRC error), length 100 -> 50 data reads issued; oRxValid stays 0; oDone with oRxErr=1.
- Ready byte 0x55, and separately length 0 and length 1600 -> oBadHeader=1; no data reads issued.
- iRst_n asserted mid RD_DATA -> all outputs return to their reset values asynchronously; the next iRxStart runs a clean sequence beginning with an index write of 0xF0.
